// File: rtl/multicast_switch_alloc.sv
// multicast_switch_alloc: per-output round-robin arbitration plus a registered
// crossbar for multicast flits. Each input tracks which labelled outputs still
// owe it a delivery, so a multicast flit may trickle out over several cycles.
//
// Handshake: valid_in[i] qualifies label/data of input i. ready_out[i] is a
// combinational pop strobe that fires in the cycle the last outstanding output
// takes the flit, or immediately for a zero label. data_in must stay stable
// until that strobe. full_in[j] is downstream back-pressure: output j neither
// transfers nor updates its register while full.
module multicast_switch_alloc #(
    parameter int PORTS    = 5,
    parameter int DATASIZE = 30
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PORTS-1:0]          valid_in,
    input  logic [PORTS*PORTS-1:0]    label_in,
    input  logic [PORTS*DATASIZE-1:0] data_in,
    input  logic [PORTS-1:0]          full_in,
    output logic [PORTS-1:0]          ready_out,
    output logic [PORTS-1:0]          valid_out,
    output logic [PORTS*DATASIZE-1:0] data_out
);

    localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [PORTS-1:0] busy;
    logic [PORTS-1:0] pend   [PORTS];
    logic [PTR_W-1:0] ptr    [PORTS];

    logic [PORTS-1:0] req    [PORTS];   // req[i][j]: input i wants output j
    logic [PORTS-1:0] grant  [PORTS];   // grant[j][i]: output j picks input i
    logic [PTR_W-1:0] gidx   [PORTS];   // index of the granted input per output
    logic [PORTS-1:0] gany;             // output j has a grant
    logic [PORTS-1:0] served [PORTS];   // served[i][j]: flit i moved to output j
    logic [PORTS-1:0] rem    [PORTS];   // outputs still owed after this cycle
    int               idx;

    // Effective request: residual mask while busy, otherwise the fresh label.
    // Held at zero during reset so no pop strobe escapes while rst_n is low.
    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            req[i] = '0;
            if (rst_n) begin
                if (busy[i])
                    req[i] = pend[i];
                else if (valid_in[i])
                    req[i] = label_in[i*PORTS +: PORTS];
            end
        end
    end

    // Round-robin search per output, starting at ptr[j] and wrapping.
    always_comb begin
        idx = 0;
        for (int j = 0; j < PORTS; j++) begin
            grant[j] = '0;
            gidx[j]  = '0;
            gany[j]  = 1'b0;
            for (int k = 0; k < PORTS; k++) begin
                idx = (int'(ptr[j]) + k) % PORTS;
                if (!gany[j] && req[idx][j]) begin
                    grant[j][idx] = 1'b1;
                    gidx[j]       = idx[PTR_W-1:0];
                    gany[j]       = 1'b1;
                end
            end
        end
    end

    // Served masks, residual masks and the pop strobe per input.
    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            served[i] = '0;
        end
        for (int j = 0; j < PORTS; j++) begin
            if (gany[j] && !full_in[j])
                served[gidx[j]][j] = 1'b1;
        end
        for (int i = 0; i < PORTS; i++) begin
            rem[i]       = req[i] & ~served[i];
            ready_out[i] = ((req[i] != '0) && (rem[i] == '0)) ||
                           (rst_n && !busy[i] && valid_in[i] &&
                            (label_in[i*PORTS +: PORTS] == '0));
        end
    end

    // Per-input residual tracking: go busy on a partial delivery, clear on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            for (int i = 0; i < PORTS; i++) pend[i] <= '0;
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                if (req[i] != '0) begin
                    if (rem[i] == '0) begin
                        busy[i] <= 1'b0;
                    end else begin
                        busy[i] <= 1'b1;
                        pend[i] <= rem[i];
                    end
                end
            end
        end
    end

    // Pointer moves past the winner only on an actual transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < PORTS; j++) ptr[j] <= '0;
        end else begin
            for (int j = 0; j < PORTS; j++) begin
                if (gany[j] && !full_in[j])
                    ptr[j] <= (int'(gidx[j]) == PORTS - 1) ? '0 : gidx[j] + 1'b1;
            end
        end
    end

    // Output registers load the granted flit (or idle) unless downstream is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= '0;
            data_out  <= '0;
        end else begin
            for (int j = 0; j < PORTS; j++) begin
                if (!full_in[j]) begin
                    valid_out[j] <= gany[j];
                    data_out[j*DATASIZE +: DATASIZE] <= gany[j] ?
                        data_in[int'(gidx[j])*DATASIZE +: DATASIZE] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multicast_switch_alloc.sv
// Directed bench for multicast_switch_alloc: inputs change on the falling
// edge, the pop strobe is checked just after, registered outputs just after
// the following rising edge.
module tb_multicast_switch_alloc;

    localparam int P = 5;
    localparam int D = 30;
    localparam int W = P * D;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [P-1:0]   valid_in;
    logic [P*P-1:0] label_in;
    logic [W-1:0]   data_in;
    logic [P-1:0]   full_in;
    logic [P-1:0]   ready_out;
    logic [P-1:0]   valid_out;
    logic [W-1:0]   data_out;

    int tests_run = 0;
    int tests_failed = 0;

    multicast_switch_alloc #(.PORTS(P), .DATASIZE(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .label_in  (label_in),
        .data_in   (data_in),
        .full_in   (full_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] dout(input int j);
        logic [W-1:0] r;
        r = '0;
        r[D-1:0] = data_out[j*D +: D];
        return r;
    endfunction

    task automatic clear_in();
        valid_in = '0;
        label_in = '0;
        data_in  = '0;
        full_in  = '0;
    endtask

    task automatic put(input int i, input logic [P-1:0] lab, input logic [D-1:0] dat);
        valid_in[i]        = 1'b1;
        label_in[i*P +: P] = lab;
        data_in[i*D +: D]  = dat;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_in();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_in();

        // ---- reset with random inputs ----
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            valid_in = P'($urandom_range(0, 31));
            label_in = P*P'($urandom);
            data_in  = {$urandom, $urandom, $urandom, $urandom, $urandom};
            full_in  = P'($urandom_range(0, 31));
            #1;
            chk("rst_ready", W'(ready_out), '0);
            chk("rst_valid", W'(valid_out), '0);
            chk("rst_data", data_out, '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_in();
        put(0, 5'b00010, 30'h1234);
        #1;
        chk("first_ready", W'(ready_out), W'(5'b00001));
        post_edge();
        chk("first_valid", W'(valid_out), W'(5'b00010));
        chk("first_data1", dout(1), W'(30'h1234));

        // ---- blocked multicast ----
        do_reset();
        @(negedge clk);
        put(2, 5'b10101, 30'hABC);
        full_in = 5'b10000;
        #1;
        chk("blk_c1_ready", W'(ready_out), '0);
        post_edge();
        chk("blk_c1_valid", W'(valid_out), W'(5'b00101));
        chk("blk_c1_data0", dout(0), W'(30'hABC));
        chk("blk_c1_data2", dout(2), W'(30'hABC));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk("blk_wait_ready", W'(ready_out), '0);
            post_edge();
            chk("blk_wait_valid", W'(valid_out), '0);
        end
        @(negedge clk);
        full_in = '0;
        #1;
        chk("blk_done_ready", W'(ready_out), W'(5'b00100));
        post_edge();
        chk("blk_done_valid", W'(valid_out), W'(5'b10000));
        chk("blk_done_data4", dout(4), W'(30'hABC));
        @(negedge clk);
        valid_in = '0;
        #1;
        chk("blk_after_ready", W'(ready_out), '0);
        post_edge();
        chk("blk_after_valid", W'(valid_out), '0);

        // ---- round robin on output 0 ----
        do_reset();
        @(negedge clk);
        put(1, 5'b00001, 30'h111);
        put(3, 5'b00001, 30'h333);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("rr_ready", W'(ready_out), (c % 2 == 0) ? W'(5'b00010) : W'(5'b01000));
            post_edge();
            chk("rr_data0", dout(0), (c % 2 == 0) ? W'(30'h111) : W'(30'h333));
            chk("rr_valid", W'(valid_out), W'(5'b00001));
            @(negedge clk);
        end

        // ---- hold on full, pointer untouched while blocked ----
        do_reset();
        @(negedge clk);
        put(4, 5'b01000, 30'h55);
        #1;
        chk("hold_first_ready", W'(ready_out), W'(5'b10000));
        post_edge();
        chk("hold_first_valid", W'(valid_out), W'(5'b01000));
        @(negedge clk);
        clear_in();
        put(0, 5'b01000, 30'h66);
        full_in = 5'b01000;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("hold_ready", W'(ready_out), '0);
            post_edge();
            chk("hold_valid", W'(valid_out), W'(5'b01000));
            chk("hold_data3", dout(3), W'(30'h55));
            @(negedge clk);
        end
        full_in = '0;
        put(2, 5'b01000, 30'h77);
        #1;
        chk("hold_ptr_ready", W'(ready_out), W'(5'b00001));
        post_edge();
        chk("hold_ptr_data3", dout(3), W'(30'h66));
        @(negedge clk);
        valid_in[0] = 1'b0;
        #1;
        chk("hold_next_ready", W'(ready_out), W'(5'b00100));
        post_edge();
        chk("hold_next_data3", dout(3), W'(30'h77));

        // ---- zero label drop ----
        do_reset();
        @(negedge clk);
        put(4, 5'b00000, 30'h999);
        #1;
        chk("zero_ready", W'(ready_out), W'(5'b10000));
        post_edge();
        chk("zero_valid", W'(valid_out), '0);
        chk("zero_data", data_out, '0);

        // ---- async reset in the middle of a blocked multicast ----
        do_reset();
        @(negedge clk);
        put(2, 5'b10101, 30'hABC);
        full_in = 5'b10000;
        post_edge();
        chk("arst_pre_valid", W'(valid_out), W'(5'b00101));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", W'(valid_out), '0);
        chk("arst_data", data_out, '0);
        chk("arst_ready", W'(ready_out), '0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_in();
        put(2, 5'b00001, 30'hDEF);
        #1;
        chk("arst_new_ready", W'(ready_out), W'(5'b00100));
        post_edge();
        chk("arst_new_valid", W'(valid_out), W'(5'b00001));
        chk("arst_new_data0", dout(0), W'(30'hDEF));
        chk("arst_new_data4", dout(4), '0);
        @(negedge clk);
        clear_in();

        // final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
